// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//
// Sequential, handshaked ALU. Takes one request at a time over a valid/ready
// input channel and returns a double-word result plus error flag over a
// valid/ready output channel.
//   ADD/SUB/AND/OR/XOR, DIV by zero, reserved opcode : result in one cycle
//   MUL (shift-add), DIV (restoring)                  : WIDTH iterations
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request present            in_ready   request can be taken
//   op[2:0]    000 ADD 001 SUB 010 MUL 011 DIV 100 AND 101 OR 110 XOR 111 rsvd
//   a, b       unsigned operands (WIDTH bits)
//   out_valid  result present             out_ready  consumer takes result
//   res_lo     sum / difference / product low / quotient / logic result
//   res_hi     carry / borrow (bit 0) / product high / remainder / zero
//   err        divide-by-zero or reserved opcode
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r, state_nx_s;
    logic [2:0]       op_r, op_nx_s;
    logic [WIDTH-1:0] b_r, b_nx_s;
    // Working registers: hi = partial product high / partial remainder,
    // lo = multiplier being shifted out / dividend shifted into quotient.
    logic [WIDTH-1:0] hi_r, hi_nx_s;
    logic [WIDTH-1:0] lo_r, lo_nx_s;
    logic [CW-1:0]    cnt_r, cnt_nx_s;

    logic             in_ready_r, in_ready_nx_s;
    logic             out_valid_r, out_valid_nx_s;
    logic [WIDTH-1:0] res_lo_r, res_lo_nx_s;
    logic [WIDTH-1:0] res_hi_r, res_hi_nx_s;
    logic             err_r, err_nx_s;

    logic             accept_s;
    logic             is_iter_s;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH:0]   div_diff_s;
    logic [WIDTH-1:0] step_hi_s;
    logic [WIDTH-1:0] step_lo_s;

    assign accept_s  = in_valid && in_ready_r;
    assign is_iter_s = (op == OP_MUL) || ((op == OP_DIV) && (b != {WIDTH{1'b0}}));

    // Single-cycle arithmetic; the top bit is the carry / borrow (a < b).
    assign add_s = {1'b0, a} + {1'b0, b};
    assign sub_s = {1'b0, a} - {1'b0, b};

    assign mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(WIDTH + 1){1'b0}});
    assign div_shift_s = {hi_r, lo_r[WIDTH-1]};
    // Partial remainder stays below b, so bit WIDTH of the difference is a
    // reliable "negative, restore" indicator.
    assign div_diff_s  = div_shift_s - {1'b0, b_r};

    // One shift-add or restoring-divide iteration.
    always_comb begin
        step_hi_s = hi_r;
        step_lo_s = lo_r;
        if (op_r == OP_MUL) begin
            step_hi_s = mul_sum_s[WIDTH:1];
            step_lo_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
        end else if (div_diff_s[WIDTH]) begin
            step_hi_s = div_shift_s[WIDTH-1:0];
            step_lo_s = {lo_r[WIDTH-2:0], 1'b0};
        end else begin
            step_hi_s = div_diff_s[WIDTH-1:0];
            step_lo_s = {lo_r[WIDTH-2:0], 1'b1};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (is_iter_s) begin
                        state_nx_s = BUSY;
                    end else begin
                        state_nx_s = DONE;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            BUSY: begin
                // Last iteration lands together with the result register.
                if (cnt_r == CW'(1)) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Output and datapath next values (all registered below).
    always_comb begin
        op_nx_s        = op_r;
        b_nx_s         = b_r;
        hi_nx_s        = hi_r;
        lo_nx_s        = lo_r;
        cnt_nx_s       = cnt_r;
        res_lo_nx_s    = res_lo_r;
        res_hi_nx_s    = res_hi_r;
        err_nx_s       = err_r;
        in_ready_nx_s  = (state_nx_s == IDLE);
        out_valid_nx_s = (state_nx_s == DONE);
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    op_nx_s = op;
                    b_nx_s  = b;
                    hi_nx_s = {WIDTH{1'b0}};
                    lo_nx_s = a;
                    if (is_iter_s) begin
                        cnt_nx_s = CW'(WIDTH);
                    end else begin
                        cnt_nx_s = {CW{1'b0}};
                        err_nx_s = 1'b0;
                        case (op)
                            OP_ADD: begin
                                res_lo_nx_s = add_s[WIDTH-1:0];
                                res_hi_nx_s = {{(WIDTH - 1){1'b0}}, add_s[WIDTH]};
                            end
                            OP_SUB: begin
                                res_lo_nx_s = sub_s[WIDTH-1:0];
                                res_hi_nx_s = {{(WIDTH - 1){1'b0}}, sub_s[WIDTH]};
                            end
                            OP_AND: begin
                                res_lo_nx_s = a & b;
                                res_hi_nx_s = {WIDTH{1'b0}};
                            end
                            OP_OR: begin
                                res_lo_nx_s = a | b;
                                res_hi_nx_s = {WIDTH{1'b0}};
                            end
                            OP_XOR: begin
                                res_lo_nx_s = a ^ b;
                                res_hi_nx_s = {WIDTH{1'b0}};
                            end
                            OP_DIV: begin
                                // Only reached with b == 0.
                                res_lo_nx_s = {WIDTH{1'b1}};
                                res_hi_nx_s = a;
                                err_nx_s    = 1'b1;
                            end
                            default: begin
                                res_lo_nx_s = {WIDTH{1'b0}};
                                res_hi_nx_s = {WIDTH{1'b0}};
                                err_nx_s    = 1'b1;
                            end
                        endcase
                    end
                end else begin
                    cnt_nx_s = cnt_r;
                end
            end
            BUSY: begin
                hi_nx_s  = step_hi_s;
                lo_nx_s  = step_lo_s;
                cnt_nx_s = cnt_r - CW'(1);
                if (cnt_r == CW'(1)) begin
                    res_lo_nx_s = step_lo_s;
                    res_hi_nx_s = step_hi_s;
                    err_nx_s    = 1'b0;
                end else begin
                    res_lo_nx_s = res_lo_r;
                end
            end
            DONE: begin
                cnt_nx_s = cnt_r;
            end
            default: begin
                cnt_nx_s = {CW{1'b0}};
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r        <= 3'b000;
            b_r         <= {WIDTH{1'b0}};
            hi_r        <= {WIDTH{1'b0}};
            lo_r        <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            res_lo_r    <= {WIDTH{1'b0}};
            res_hi_r    <= {WIDTH{1'b0}};
            err_r       <= 1'b0;
        end else begin
            op_r        <= op_nx_s;
            b_r         <= b_nx_s;
            hi_r        <= hi_nx_s;
            lo_r        <= lo_nx_s;
            cnt_r       <= cnt_nx_s;
            in_ready_r  <= in_ready_nx_s;
            out_valid_r <= out_valid_nx_s;
            res_lo_r    <= res_lo_nx_s;
            res_hi_r    <= res_hi_nx_s;
            err_r       <= err_nx_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign res_lo    = res_lo_r;
    assign res_hi    = res_hi_r;
    assign err       = err_r;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
//
// Directed bench for alu_seq. One 32-bit and one 8-bit instance share clock
// and reset. Inputs are driven and outputs sampled on the falling edge; the
// latency count k is the number of falling edges after the accepting rising
// edge up to and including the first one that shows out_valid.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    logic        clk;
    logic        rst_n;

    logic        in_valid32, in_ready32, out_valid32, out_ready32, err32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, res_lo32, res_hi32;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, err8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, res_lo8, res_hi8;

    int tests;
    int fails;

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid32), .in_ready(in_ready32),
        .op(op32), .a(a32), .b(b32),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .res_lo(res_lo32), .res_hi(res_hi32), .err(err32)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .res_lo(res_lo8), .res_hi(res_hi8), .err(err8)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request on the 32-bit instance, check latency/result, consume it.
    task automatic run32(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] elo,
                         input logic [31:0] ehi, input logic eerr, input int elat);
        int  k;
        bit  rdy_bad;
        @(negedge clk);
        check({tag, "_in_ready_idle"}, {63'd0, in_ready32}, 64'd1);
        op32 = o; a32 = x; b32 = y; in_valid32 = 1'b1; out_ready32 = 1'b0;
        @(posedge clk);
        k = 0;
        rdy_bad = 1'b0;
        while (k < 100) begin
            @(negedge clk);
            in_valid32 = 1'b0;
            k++;
            if (in_ready32 !== 1'b0) rdy_bad = 1'b1;
            if (out_valid32 === 1'b1) break;
        end
        check({tag, "_latency"}, 64'(k), 64'(elat));
        check({tag, "_in_ready_busy"}, {63'd0, rdy_bad}, 64'd0);
        check({tag, "_res_lo"}, {32'd0, res_lo32}, {32'd0, elo});
        check({tag, "_res_hi"}, {32'd0, res_hi32}, {32'd0, ehi});
        check({tag, "_err"}, {63'd0, err32}, {63'd0, eerr});
        out_ready32 = 1'b1;
        @(negedge clk);
        out_ready32 = 1'b0;
        check({tag, "_out_valid_after"}, {63'd0, out_valid32}, 64'd0);
    endtask

    // Same for the 8-bit instance.
    task automatic run8(input string tag, input logic [2:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] elo,
                        input logic [7:0] ehi, input logic eerr, input int elat);
        int  k;
        bit  rdy_bad;
        @(negedge clk);
        check({tag, "_in_ready_idle"}, {63'd0, in_ready8}, 64'd1);
        op8 = o; a8 = x; b8 = y; in_valid8 = 1'b1; out_ready8 = 1'b0;
        @(posedge clk);
        k = 0;
        rdy_bad = 1'b0;
        while (k < 100) begin
            @(negedge clk);
            in_valid8 = 1'b0;
            k++;
            if (in_ready8 !== 1'b0) rdy_bad = 1'b1;
            if (out_valid8 === 1'b1) break;
        end
        check({tag, "_latency"}, 64'(k), 64'(elat));
        check({tag, "_in_ready_busy"}, {63'd0, rdy_bad}, 64'd0);
        check({tag, "_res_lo"}, {56'd0, res_lo8}, {56'd0, elo});
        check({tag, "_res_hi"}, {56'd0, res_hi8}, {56'd0, ehi});
        check({tag, "_err"}, {63'd0, err8}, {63'd0, eerr});
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        check({tag, "_out_valid_after"}, {63'd0, out_valid8}, 64'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        in_valid32 = 1'b0; out_ready32 = 1'b0; op32 = 3'd0; a32 = 32'd0; b32 = 32'd0;
        in_valid8  = 1'b0; out_ready8  = 1'b0; op8  = 3'd0; a8  = 8'd0;  b8  = 8'd0;

        // Reset held for three cycles, then released.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready",  {63'd0, in_ready32},  64'd1);
        check("rst_out_valid", {63'd0, out_valid32}, 64'd0);
        check("rst_res_lo",    {32'd0, res_lo32},    64'd0);
        check("rst_res_hi",    {32'd0, res_hi32},    64'd0);
        check("rst_err",       {63'd0, err32},       64'd0);
        check("rst8_in_ready", {63'd0, in_ready8},   64'd1);

        // Single-cycle arithmetic and logic, WIDTH=32.
        run32("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1'b0, 1);
        run32("sub_brw",  3'b001, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1);
        run32("and",      3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 32'h0000_0000, 1'b0, 1);
        run32("or",       3'b101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 32'h0000_0000, 1'b0, 1);
        run32("xor",      3'b110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 32'h0000_0000, 1'b0, 1);

        // Iterative ops, WIDTH=32.
        run32("mul_max",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 33);
        run32("div32",    3'b011, 32'd1000000,   32'd7,         32'd142857,    32'd1,         1'b0, 33);

        // WIDTH=8 divide, multiply and error cases.
        run8("div_200_7", 3'b011, 8'd200,  8'd7,   8'd28,   8'd4,   1'b0, 9);
        run8("div_small", 3'b011, 8'd5,    8'd9,   8'd0,    8'd5,   1'b0, 9);
        run8("div_zero",  3'b011, 8'h55,   8'h00,  8'hFF,   8'h55,  1'b1, 1);
        run8("rsvd_op",   3'b111, 8'h3C,   8'hA5,  8'h00,   8'h00,  1'b1, 1);
        run8("mul8",      3'b010, 8'd13,   8'd11,  8'h8F,   8'h00,  1'b0, 9);
        run8("mul8_max",  3'b010, 8'hFF,   8'hFF,  8'h01,   8'hFE,  1'b0, 9);

        // Backpressure: XOR result held with out_ready low while a second
        // request waits on in_valid.
        @(negedge clk);
        op32 = 3'b110; a32 = 32'hF0F0_F0F0; b32 = 32'h0FF0_0FF0; in_valid32 = 1'b1; out_ready32 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        op32 = 3'b000; a32 = 32'd1; b32 = 32'd2;   // second request, in_valid stays high
        check("bp_first_valid", {63'd0, out_valid32}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", {63'd0, out_valid32}, 64'd1);
            check("bp_hold_lo",    {32'd0, res_lo32},    {32'd0, 32'hFF00_FF00});
            check("bp_hold_hi",    {32'd0, res_hi32},    64'd0);
            check("bp_hold_ready", {63'd0, in_ready32},  64'd0);
        end
        out_ready32 = 1'b1;
        @(negedge clk);                            // handshake edge M passed
        check("bp_ready_back", {63'd0, in_ready32},  64'd1);
        check("bp_valid_drop", {63'd0, out_valid32}, 64'd0);
        @(negedge clk);                            // edge M+1 accepted the ADD
        in_valid32 = 1'b0;
        check("bp_next_valid", {63'd0, out_valid32}, 64'd1);
        check("bp_next_lo",    {32'd0, res_lo32},    64'd3);
        @(negedge clk);
        out_ready32 = 1'b0;
        check("bp_next_done",  {63'd0, out_valid32}, 64'd0);

        // Reset in the middle of a multiply.
        @(negedge clk);
        op32 = 3'b010; a32 = 32'd12345; b32 = 32'd678; in_valid32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid32 = 1'b0;
        repeat (5) @(negedge clk);
        check("midmul_busy", {63'd0, in_ready32}, 64'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready",  {63'd0, in_ready32},  64'd1);
        check("midrst_out_valid", {63'd0, out_valid32}, 64'd0);
        check("midrst_res_lo",    {32'd0, res_lo32},    64'd0);
        check("midrst_res_hi",    {32'd0, res_hi32},    64'd0);
        check("midrst_err",       {63'd0, err32},       64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run32("add_after_rst", 3'b000, 32'd10, 32'd20, 32'd30, 32'd0, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
